// File: rtl/sponge_ctrl_if.sv
// Control bundle between sponge_ctrl and the Keccak datapath / message source / digest sink.
// The master modport is the controller side; the perf counters exist only with SPONGE_CTRL_PERF_EN.
interface sponge_ctrl_if;
  logic       blk_valid;
  logic       blk_last;
  logic       blk_ready;
  logic       abort;
  logic       absorb_en;
  logic       flag_rounds_completed;
  logic       round_en;
  logic [4:0] round_idx;
  logic       state_clr;
  logic       digest_valid;
  logic       digest_ready;
  logic       busy;
`ifdef SPONGE_CTRL_PERF_EN
  logic [15:0] blk_count;
  logic [31:0] perm_cycles;
`endif

  modport master (
    input  blk_valid, blk_last, abort, digest_ready,
    output blk_ready, absorb_en, flag_rounds_completed, round_en, round_idx,
           state_clr, digest_valid, busy
`ifdef SPONGE_CTRL_PERF_EN
    , output blk_count, perm_cycles
`endif
  );

  modport slave (
    output blk_valid, blk_last, abort, digest_ready,
    input  blk_ready, absorb_en, flag_rounds_completed, round_en, round_idx,
           state_clr, digest_valid, busy
`ifdef SPONGE_CTRL_PERF_EN
    , input blk_count, perm_cycles
`endif
  );
endinterface

// File: rtl/sponge_ctrl.sv
// Keccak-f[1600] sponge sequencer (SHA3-256); optional perf counters under SPONGE_CTRL_PERF_EN.
// Latency: absorb at handshake t, rounds t+1..t+NUM_ROUNDS/ROUNDS_PER_CYCLE, next state after that.
// Backpressure: blk_ready low while permuting or holding the digest; digest held until digest_ready.
module sponge_ctrl #(
  parameter int NUM_ROUNDS       = 24,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic          clk,
  input logic          rst_n,
  sponge_ctrl_if.master bus
);

  if ((NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0 || NUM_ROUNDS > 31) begin : g_bad_cfg
    $error("sponge_ctrl: ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
  end

  localparam logic [4:0] RPC      = 5'(ROUNDS_PER_CYCLE);
  localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
  localparam logic [4:0] NR       = 5'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, WAIT_BLK, PERMUTE, DONE} state_t;

  state_t     state;
  logic [4:0] round_idx_q;
  logic       last_q;
  logic       blk_ready_q;
  logic       flag_q;
  logic       round_en_q;
  logic       digest_valid_q;
  logic       busy_q;

  logic       handshake;
  logic       consume;
  logic       round_en;
  logic       state_clr;

  // abort masks the datapath strobes in its own cycle
  assign handshake = bus.blk_valid & blk_ready_q & ~bus.abort;
  assign consume   = digest_valid_q & bus.digest_ready;
  assign round_en  = round_en_q & ~bus.abort;
  assign state_clr = bus.abort | consume;

  assign bus.blk_ready             = blk_ready_q;
  assign bus.flag_rounds_completed = flag_q;
  assign bus.absorb_en             = handshake;
  assign bus.round_en              = round_en;
  assign bus.round_idx             = round_idx_q;
  assign bus.state_clr             = state_clr;
  assign bus.digest_valid          = digest_valid_q;
  assign bus.busy                  = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      round_idx_q    <= '0;
      last_q         <= 1'b0;
      blk_ready_q    <= 1'b1;
      flag_q         <= 1'b1;
      round_en_q     <= 1'b0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else if (bus.abort) begin
      state          <= IDLE;
      round_idx_q    <= '0;
      last_q         <= 1'b0;
      blk_ready_q    <= 1'b1;
      flag_q         <= 1'b1;
      round_en_q     <= 1'b0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state)
        IDLE, WAIT_BLK: begin
          if (handshake) begin
            state       <= PERMUTE;
            last_q      <= bus.blk_last;
            round_idx_q <= '0;
            blk_ready_q <= 1'b0;
            flag_q      <= 1'b0;
            round_en_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        PERMUTE: begin
          if (round_idx_q == LAST_IDX) begin
            round_idx_q <= '0;
            round_en_q  <= 1'b0;
            flag_q      <= 1'b1;
            if (last_q) begin
              state          <= DONE;
              digest_valid_q <= 1'b1;
            end else begin
              state       <= WAIT_BLK;
              blk_ready_q <= 1'b1;
            end
          end else begin
            round_idx_q <= round_idx_q + RPC;
          end
        end
        DONE: begin
          if (bus.digest_ready) begin
            state          <= IDLE;
            digest_valid_q <= 1'b0;
            blk_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            last_q         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPONGE_CTRL_PERF_EN
  logic [15:0] blk_count_q;
  logic [31:0] perm_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count_q   <= '0;
      perm_cycles_q <= '0;
    end else begin
      if (state_clr)
        blk_count_q <= '0;
      else if (handshake && blk_count_q != 16'hFFFF)
        blk_count_q <= blk_count_q + 16'd1;
      if (round_en)
        perm_cycles_q <= perm_cycles_q + 32'd1;
    end
  end

  assign bus.blk_count   = blk_count_q;
  assign bus.perm_cycles = perm_cycles_q;
`endif

  a_round_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
    round_idx_q < NR);
  a_absorb_round_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(handshake && round_en));
  a_absorb_flag: assert property (@(posedge clk) disable iff (!rst_n)
    handshake |-> flag_q);

endmodule

// File: tb/tb_sponge_ctrl.sv
// Directed bench for sponge_ctrl: one instance at 1 round/cycle, one at 4 rounds/cycle.
module tb_sponge_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cnt;
`ifdef SPONGE_CTRL_PERF_EN
  logic [31:0] pc0;
`endif

  always #5 clk = ~clk;

  sponge_ctrl_if bus1();
  sponge_ctrl_if bus4();

  sponge_ctrl #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus1));
  sponge_ctrl #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake cycle on bus1; returns 1ns into the first permutation cycle.
  task automatic hs1(input logic last, input string tag);
    bus1.blk_valid = 1'b1;
    bus1.blk_last  = last;
    #1;
    check(tag, 32'(bus1.absorb_en), 1);
    tick();
    bus1.blk_valid = 1'b0;
    bus1.blk_last  = 1'b0;
  endtask

  task automatic perm(input int n, input logic chk_idx, input string tag, inout int c);
    for (int i = 0; i < n; i++) begin
      if (bus1.round_en === 1'b1) c++;
      if (chk_idx) check(tag, 32'(bus1.round_idx), 32'(i));
      tick();
    end
  endtask

  initial begin
    bus1.blk_valid = 0; bus1.blk_last = 0; bus1.abort = 0; bus1.digest_ready = 0;
    bus4.blk_valid = 0; bus4.blk_last = 0; bus4.abort = 0; bus4.digest_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_blk_ready", 32'(bus1.blk_ready), 1);
    check("rst_flag", 32'(bus1.flag_rounds_completed), 1);
    check("rst_round_en", 32'(bus1.round_en), 0);
    check("rst_round_idx", 32'(bus1.round_idx), 0);
    check("rst_digest_valid", 32'(bus1.digest_valid), 0);
    check("rst_busy", 32'(bus1.busy), 0);
    check("rst_state_clr", 32'(bus1.state_clr), 0);
    check("rst_absorb_en", 32'(bus1.absorb_en), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 4 rounds per cycle: idx 0,4,..,20 then digest at t+7
    bus4.blk_valid = 1'b1; bus4.blk_last = 1'b1;
    #1 check("r4_absorb", 32'(bus4.absorb_en), 1);
    tick();
    bus4.blk_valid = 1'b0; bus4.blk_last = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("r4_round_en", 32'(bus4.round_en), 1);
      check("r4_round_idx", 32'(bus4.round_idx), 32'(i * 4));
      tick();
    end
    check("r4_digest_valid", 32'(bus4.digest_valid), 1);
    check("r4_round_en_off", 32'(bus4.round_en), 0);
    bus4.digest_ready = 1'b1;
    #1 check("r4_state_clr", 32'(bus4.state_clr), 1);
    tick();
    bus4.digest_ready = 1'b0;
    check("r4_idle_ready", 32'(bus4.blk_ready), 1);

    // single block, blk_valid held high during the permutation
    hs1(1'b1, "t1_absorb");
    bus1.blk_valid = 1'b1;
    #1 check("t1_absorb_ignored", 32'(bus1.absorb_en), 0);
    check("t1_busy", 32'(bus1.busy), 1);
    cnt = 0;
    perm(24, 1'b1, "t1_round_idx", cnt);
    bus1.blk_valid = 1'b0;
    check("t1_round_cnt", 32'(cnt), 24);
    check("t1_digest_valid", 32'(bus1.digest_valid), 1);
    check("t1_round_en_off", 32'(bus1.round_en), 0);
    check("t1_blk_ready_done", 32'(bus1.blk_ready), 0);
    tick();
    tick();
    bus1.digest_ready = 1'b1;
    #1 check("t1_state_clr", 32'(bus1.state_clr), 1);
    tick();
    bus1.digest_ready = 1'b0;
    check("t1_blk_ready_after", 32'(bus1.blk_ready), 1);
    check("t1_digest_cleared", 32'(bus1.digest_valid), 0);
    check("t1_idle_busy", 32'(bus1.busy), 0);
    check("t1_state_clr_off", 32'(bus1.state_clr), 0);

    // three-block message
`ifdef SPONGE_CTRL_PERF_EN
    pc0 = bus1.perm_cycles;
`endif
    cnt = 0;
    for (int b = 0; b < 2; b++) begin
      hs1(1'b0, "t2_absorb");
      perm(24, 1'b0, "", cnt);
      check("t2_wait_busy", 32'(bus1.busy), 1);
      check("t2_wait_ready", 32'(bus1.blk_ready), 1);
      check("t2_wait_no_digest", 32'(bus1.digest_valid), 0);
    end
    hs1(1'b1, "t2_absorb_last");
    perm(24, 1'b0, "", cnt);
    check("t2_round_cnt", 32'(cnt), 72);
    check("t2_digest_valid", 32'(bus1.digest_valid), 1);
`ifdef SPONGE_CTRL_PERF_EN
    check("perf_blk_count", 32'(bus1.blk_count), 3);
    check("perf_perm_cycles", bus1.perm_cycles - pc0, 72);
`endif

    // backpressure on the digest with a block waiting
    bus1.blk_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t3_digest_held", 32'(bus1.digest_valid), 1);
      check("t3_blk_ready", 32'(bus1.blk_ready), 0);
      check("t3_no_absorb", 32'(bus1.absorb_en), 0);
      tick();
    end
    bus1.digest_ready = 1'b1;
    #1 check("t3_state_clr", 32'(bus1.state_clr), 1);
    check("t3_absorb_blocked", 32'(bus1.absorb_en), 0);
    tick();
    bus1.digest_ready = 1'b0;
    #1 check("t3_absorb_next", 32'(bus1.absorb_en), 1);
`ifdef SPONGE_CTRL_PERF_EN
    check("perf_blk_count_clr", 32'(bus1.blk_count), 0);
`endif
    tick();
    bus1.blk_valid = 1'b0;

    // abort at round_idx 7
    cnt = 0;
    perm(7, 1'b0, "", cnt);
    check("t4_idx7", 32'(bus1.round_idx), 7);
    bus1.abort = 1'b1;
    #1 check("t4_state_clr", 32'(bus1.state_clr), 1);
    check("t4_round_en_masked", 32'(bus1.round_en), 0);
    tick();
    bus1.abort = 1'b0;
    check("t4_idx_clr", 32'(bus1.round_idx), 0);
    check("t4_idle_busy", 32'(bus1.busy), 0);
    check("t4_idle_ready", 32'(bus1.blk_ready), 1);
    check("t4_round_en_off", 32'(bus1.round_en), 0);
    bus1.abort = 1'b1;
    #1 check("t4_idle_abort_clr", 32'(bus1.state_clr), 1);
    tick();
    bus1.abort = 1'b0;
    hs1(1'b1, "t4_absorb");
    cnt = 0;
    perm(24, 1'b1, "t4_round_idx", cnt);
    check("t4_round_cnt", 32'(cnt), 24);
    check("t4_digest_valid", 32'(bus1.digest_valid), 1);
    bus1.digest_ready = 1'b1;
    tick();
    bus1.digest_ready = 1'b0;

    // asynchronous reset mid-permutation
    hs1(1'b1, "t5_absorb");
    cnt = 0;
    perm(5, 1'b0, "", cnt);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_round_en", 32'(bus1.round_en), 0);
    check("t5_rst_idx", 32'(bus1.round_idx), 0);
    check("t5_rst_ready", 32'(bus1.blk_ready), 1);
    check("t5_rst_busy", 32'(bus1.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sponge_ctrl.md
Name: sponge_ctrl

Overview:
- Sequencing controller for the Keccak-f[1600] sponge datapath (SHA3-256 rate, 1088-bit blocks).
- Accepts message-block handshakes and drives the absorb stage (`flag_rounds_completed`, absorb enable).
- Steps the round function through `NUM_ROUNDS` rounds and signals digest availability.
- Holds no state data: the 1600-bit state register and the round logic live in the datapath; this block only generates the controls.

Parameters:
- NUM_ROUNDS, 24: Keccak-f rounds per permutation.
- ROUNDS_PER_CYCLE, 1: rounds the datapath evaluates per clock. Must divide NUM_ROUNDS; legal values are 1, 2, 3, 4, 6, 8, 12, 24.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  upstream has a padded 1088-bit block on the datapath input.
- blk_last  in  1  the current block is the final block of the message; qualified by blk_valid.
- blk_ready  out  1  controller accepts a block this cycle.
- abort  in  1  synchronous message abort.
- absorb_en  out  1  datapath loads the absorb-stage next_state into the state register at this edge.
- flag_rounds_completed  out  1  to absorb stage; 1 means xor the block into the state, 0 means pass the state through.
- round_en  out  1  datapath applies ROUNDS_PER_CYCLE rounds this cycle.
- round_idx  out  5  index of the first round evaluated this cycle.
- state_clr  out  1  datapath zeroes the state register at this edge.
- digest_valid  out  1  the state holds the final digest (bits [1599:1344]).
- digest_ready  in  1  downstream consumes the digest.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - FSM = IDLE, round_idx = 0, last_q = 0.
  - All outputs 0 except blk_ready = 1 and flag_rounds_completed = 1.
- States: IDLE, WAIT_BLK, PERMUTE, DONE.

IDLE and WAIT_BLK:
- blk_ready = 1 and flag_rounds_completed = 1.
- absorb_en = blk_valid & blk_ready. It is combinational, high only in the handshake cycle.
- On handshake: last_q <= blk_last, round_idx <= 0, go to PERMUTE.
- busy = 0 in IDLE and 1 in WAIT_BLK, which is mid-message.

PERMUTE:
- blk_ready = 0, flag_rounds_completed = 0, round_en = 1.
- round_idx advances by ROUNDS_PER_CYCLE each cycle.
- When round_idx == NUM_ROUNDS-ROUNDS_PER_CYCLE, the permutation is complete after this cycle. Next state is DONE if last_q = 1, else WAIT_BLK.
- round_idx returns to 0 on exit.
- Duration: exactly NUM_ROUNDS/ROUNDS_PER_CYCLE cycles; blk_valid is ignored throughout.

DONE:
- digest_valid = 1, held steady until digest_ready.
- On digest_valid & digest_ready: state_clr = 1 (combinational, that cycle only), go to IDLE.
- blk_ready = 0, so no new message is accepted until the digest is consumed.

Latency (ROUNDS_PER_CYCLE = 1):
- Block handshake at cycle t, so absorb_en is high at t.
- round_en is high at t+1..t+24, with round_idx 0..23.
- Next state reached at t+25: DONE (digest_valid = 1) or WAIT_BLK (blk_ready = 1).

abort:
- From any state, abort = 1 forces IDLE next cycle with state_clr = 1 that cycle.
- absorb_en and round_en are forced to 0 in that cycle.
- round_idx and last_q are cleared.
- abort takes priority over every other event.
- abort in IDLE still pulses state_clr.

Simultaneous events:
- blk_valid together with digest_ready in DONE: the digest is consumed and the block is not accepted. It is accepted in IDLE on the next cycle.
- blk_last is sampled only at the handshake.
- Reset asserted mid-PERMUTE: asynchronous return to IDLE. The datapath state is not cleared by this block; the datapath reset covers it.

Assertions the implementation carries:
- round_idx < NUM_ROUNDS.
- absorb_en and round_en never high together.
- absorb_en implies flag_rounds_completed.

Optional Feature:
- Macro: SPONGE_CTRL_PERF_EN.
- Defined:
  - Adds output blk_count [15:0], counting absorb_en pulses in the current message. It saturates at 16'hFFFF and is cleared on state_clr and reset.
  - Adds output perm_cycles [31:0], a free-running count of cycles with round_en = 1. It wraps at 2^32 and is cleared only by reset.
- Not defined: neither port exists and the logic is absent; all other behaviour is identical.

Test Plan:
- Single block (blk_valid = 1, blk_last = 1 at t) -> absorb_en high at t only, round_en high t+1..t+24 with round_idx 0..23, digest_valid at t+25. With digest_ready = 1 at t+27: state_clr pulses at t+27, blk_ready = 1 at t+28.
- Three-block message (blk_last only on the third block) -> WAIT_BLK after permutations 1 and 2 with busy = 1 and blk_ready = 1. Exactly 72 round_en cycles in total, digest_valid after the third permutation.
- Backpressure: digest_ready held 0 for 10 cycles with blk_valid = 1 -> digest_valid held, blk_ready = 0, no absorb_en until the digest is consumed.
- abort at round_idx = 7 -> next cycle IDLE, state_clr = 1 in the abort cycle, round_en = 0, round_idx = 0. A new block then gives a full 24-cycle permutation.
- ROUNDS_PER_CYCLE = 4 -> round_idx sequence 0, 4, 8, 12, 16, 20 over 6 cycles, digest_valid at t+7.
- SPONGE_CTRL_PERF_EN defined, 3-block message -> blk_count = 3 at DONE and 0 after state_clr; perm_cycles = 72.
